instr_chain_node: RTL and testbench

Parametrised instruction-distribution node for one cell position in a row of the fabric. It sits on the row's serial instruction chain and its call/ret daisy chain.
- Instructions whose hop count is 0 are delivered into a local buffered FIFO with a valid/ready interface.
- All other instructions are forwarded with hops decremented, through a configurable number of pipeline stages.
- A call/ret state machine sequences execution. ret is returned upstream only when downstream has returned, the local FIFO has drained and the local resource reports done.

---
 rtl/instr_chain_node.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_chain_node.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_chain_node.sv
// instr_chain_node: one cell position on a row's serial instruction chain and
// call/ret daisy chain. Words with zero hops land in a local show-ahead FIFO;
// all other words are forwarded with hops decremented through FWD_STAGES
// registers. A three-state FSM returns ret upstream once downstream has
// returned, the local FIFO and forward pipeline are empty and the local
// resource reports done.
// Optional build macro INSTR_CHAIN_NODE_BCAST_EN: an all-ones hop count is a
// broadcast, delivered locally and forwarded with hops unchanged.
module instr_chain_node #(
    parameter int unsigned INSTR_DATA_WIDTH = 32,
    parameter int unsigned INSTR_ADDR_WIDTH = 6,
    parameter int unsigned INSTR_HOPS_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned FWD_STAGES       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          call_in,
    output logic                          call_out,
    input  logic                          ret_in,
    output logic                          ret_out,
    input  logic [INSTR_DATA_WIDTH-1:0]   instr_data_in,
    input  logic [INSTR_ADDR_WIDTH-1:0]   instr_addr_in,
    input  logic [INSTR_HOPS_WIDTH-1:0]   instr_hops_in,
    input  logic                          instr_en_in,
    output logic [INSTR_DATA_WIDTH-1:0]   instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0]   instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0]   instr_hops_out,
    output logic                          instr_en_out,
    output logic                          loc_valid,
    input  logic                          loc_ready,
    output logic [INSTR_DATA_WIDTH-1:0]   loc_data,
    output logic [INSTR_ADDR_WIDTH-1:0]   loc_addr,
    input  logic                          loc_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;

    localparam logic [INSTR_HOPS_WIDTH-1:0] HOP_ONE   = INSTR_HOPS_WIDTH'(1);
    localparam logic [PTR_W-1:0]            PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]            CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]            DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Chain decode
    // ------------------------------------------------------------------
    logic                        is_bcast;
    logic                        is_local;
    logic                        is_fwd;
    logic [INSTR_HOPS_WIDTH-1:0] fwd_hops;

    // Classify the incoming chain word and compute its outgoing hop count.
    always_comb begin
        is_bcast = 1'b0;
`ifdef INSTR_CHAIN_NODE_BCAST_EN
        is_bcast = (instr_hops_in == '1);
`endif
        is_local = instr_en_in && ((instr_hops_in == '0) || is_bcast);
        is_fwd   = instr_en_in && (instr_hops_in != '0);
        fwd_hops = is_bcast ? instr_hops_in : (instr_hops_in - HOP_ONE);
    end

    // ------------------------------------------------------------------
    // Forward pipeline
    // ------------------------------------------------------------------
    logic [FWD_STAGES-1:0]       stage_en;
    logic [INSTR_DATA_WIDTH-1:0] stage_data [FWD_STAGES];
    logic [INSTR_ADDR_WIDTH-1:0] stage_addr [FWD_STAGES];
    logic [INSTR_HOPS_WIDTH-1:0] stage_hops [FWD_STAGES];
    logic                        fwd_busy;

    // Shift forwarded words through the stages; payload is zeroed when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_en <= '0;
            for (int unsigned i = 0; i < FWD_STAGES; i++) begin
                stage_data[i] <= '0;
                stage_addr[i] <= '0;
                stage_hops[i] <= '0;
            end
        end else begin
            stage_en[0]   <= is_fwd;
            stage_data[0] <= is_fwd ? instr_data_in : '0;
            stage_addr[0] <= is_fwd ? instr_addr_in : '0;
            stage_hops[0] <= is_fwd ? fwd_hops      : '0;
            for (int unsigned i = 1; i < FWD_STAGES; i++) begin
                stage_en[i]   <= stage_en[i-1];
                stage_data[i] <= stage_data[i-1];
                stage_addr[i] <= stage_addr[i-1];
                stage_hops[i] <= stage_hops[i-1];
            end
        end
    end

    assign fwd_busy       = |stage_en;
    assign instr_en_out   = stage_en[FWD_STAGES-1];
    assign instr_data_out = stage_data[FWD_STAGES-1];
    assign instr_addr_out = stage_addr[FWD_STAGES-1];
    assign instr_hops_out = stage_hops[FWD_STAGES-1];

    // ------------------------------------------------------------------
    // Local FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic              enter_run;

    // A push into a full FIFO is still accepted when the head pops the same cycle.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_CNT);
        pop        = !fifo_empty && loc_ready;
        push       = is_local && (!fifo_full || pop);
        drop       = is_local && fifo_full && !pop;
    end

    // Storage array; contents need no reset because outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {instr_addr_in, instr_data_in};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as the IDLE->RUN clear still sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow && !enter_run) || drop;
        end
    end

    assign head       = mem[rd_ptr];
    assign loc_valid  = !fifo_empty;
    assign loc_data   = fifo_empty ? '0 : head[INSTR_DATA_WIDTH-1:0];
    assign loc_addr   = fifo_empty ? '0 : head[WORD_W-1:INSTR_DATA_WIDTH];
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Call/ret FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   done_cond;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and call/ret outputs; a falling call_in beats completion.
    always_comb begin
        state_next = state;
        call_out   = 1'b0;
        ret_out    = 1'b0;
        enter_run  = 1'b0;
        done_cond  = ret_in && loc_done && fifo_empty && !fwd_busy;
        unique case (state)
            IDLE: begin
                if (call_in) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                call_out = 1'b1;
                if (!call_in) begin
                    state_next = IDLE;
                end else if (done_cond) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                call_out = 1'b1;
                ret_out  = 1'b1;
                if (!call_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_chain_node.sv
// Self-checking bench for instr_chain_node: directed steps followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_instr_chain_node;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned HW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FS    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          call_in = 1'b0;
    logic          call_out;
    logic          ret_in = 1'b0;
    logic          ret_out;
    logic [DW-1:0] instr_data_in = '0;
    logic [AW-1:0] instr_addr_in = '0;
    logic [HW-1:0] instr_hops_in = '0;
    logic          instr_en_in = 1'b0;
    logic [DW-1:0] instr_data_out;
    logic [AW-1:0] instr_addr_out;
    logic [HW-1:0] instr_hops_out;
    logic          instr_en_out;
    logic          loc_valid;
    logic          loc_ready = 1'b0;
    logic [DW-1:0] loc_data;
    logic [AW-1:0] loc_addr;
    logic          loc_done = 1'b0;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    instr_chain_node #(
        .INSTR_DATA_WIDTH(DW),
        .INSTR_ADDR_WIDTH(AW),
        .INSTR_HOPS_WIDTH(HW),
        .FIFO_DEPTH(DEPTH),
        .FWD_STAGES(FS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .call_in(call_in),
        .call_out(call_out),
        .ret_in(ret_in),
        .ret_out(ret_out),
        .instr_data_in(instr_data_in),
        .instr_addr_in(instr_addr_in),
        .instr_hops_in(instr_hops_in),
        .instr_en_in(instr_en_in),
        .instr_data_out(instr_data_out),
        .instr_addr_out(instr_addr_out),
        .instr_hops_out(instr_hops_out),
        .instr_en_out(instr_en_out),
        .loc_valid(loc_valid),
        .loc_ready(loc_ready),
        .loc_data(loc_data),
        .loc_addr(loc_addr),
        .loc_done(loc_done),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } loc_word_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [HW-1:0] h;
    } fwd_word_t;

    // Reference model state
    loc_word_t lq[$];
    fwd_word_t fq[$];
    bit        m_active;
    bit        m_returned;
    bit        m_ovf;
    int        cyc;

    int total;
    int bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        logic [HW-1:0] eh;
        logic          ee;
        check("call_out", 64'(call_out), 64'(m_active));
        check("ret_out", 64'(ret_out), 64'(m_returned));
        check("loc_valid", 64'(loc_valid), 64'(lq.size() != 0));
        check("fifo_count", 64'(fifo_count), 64'(lq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        ed = '0;
        ea = '0;
        if (lq.size() != 0) begin
            ed = lq[0].d;
            ea = lq[0].a;
        end
        check("loc_data", 64'(loc_data), 64'(ed));
        check("loc_addr", 64'(loc_addr), 64'(ea));
        ee = 1'b0;
        ed = '0;
        ea = '0;
        eh = '0;
        if (fq.size() != 0 && fq[0].due == cyc) begin
            ee = 1'b1;
            ed = fq[0].d;
            ea = fq[0].a;
            eh = fq[0].h;
        end
        check("instr_en_out", 64'(instr_en_out), 64'(ee));
        check("instr_data_out", 64'(instr_data_out), 64'(ed));
        check("instr_addr_out", 64'(instr_addr_out), 64'(ea));
        check("instr_hops_out", 64'(instr_hops_out), 64'(eh));
    endtask

    task automatic model_reset();
        lq.delete();
        fq.delete();
        m_active   = 1'b0;
        m_returned = 1'b0;
        m_ovf      = 1'b0;
    endtask

    // Advance one clock: update the model from the inputs held this cycle,
    // let the edge happen, then compare every output.
    task automatic tick();
        bit busy;
        bit empty;
        bit full;
        bit pop;
        bit push;
        bit drop;
        bit bcast;
        bit clr;
        fwd_word_t fw;
        loc_word_t lw;

        busy  = (fq.size() != 0);
        while (fq.size() != 0 && fq[0].due <= cyc) void'(fq.pop_front());
        empty = (lq.size() == 0);
        full  = (lq.size() == DEPTH);

        clr = 1'b0;
        if (!m_active) begin
            if (call_in) begin
                m_active = 1'b1;
                clr      = 1'b1;
            end
        end else if (!m_returned) begin
            if (!call_in) m_active = 1'b0;
            else if (ret_in && loc_done && empty && !busy) m_returned = 1'b1;
        end else if (!call_in) begin
            m_active   = 1'b0;
            m_returned = 1'b0;
        end

        bcast = 1'b0;
`ifdef INSTR_CHAIN_NODE_BCAST_EN
        bcast = (int'(instr_hops_in) == (1 << HW) - 1);
`endif
        pop  = !empty && loc_ready;
        push = instr_en_in && (instr_hops_in == 0 || bcast);
        drop = push && full && !pop;
        if (clr) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (pop) void'(lq.pop_front());
        if (push && !drop) begin
            lw.d = instr_data_in;
            lw.a = instr_addr_in;
            lq.push_back(lw);
        end
        if (instr_en_in && instr_hops_in != 0) begin
            fw.due = cyc + FS;
            fw.d   = instr_data_in;
            fw.a   = instr_addr_in;
            fw.h   = bcast ? instr_hops_in : HW'(int'(instr_hops_in) - 1);
            fq.push_back(fw);
        end

        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic word(input bit en, input int hops, input logic [DW-1:0] d, input logic [AW-1:0] a);
        instr_en_in   = en;
        instr_hops_in = HW'(hops);
        instr_data_in = en ? d : '0;
        instr_addr_in = en ? a : '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        model_reset();

        // Power-on reset
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Forward path: hops 3 -> 2 after FS cycles
        word(1, 3, 32'hDEADBEEF, 6'd5);
        tick();
        word(0, 0, '0, '0);
        repeat (3) tick();

        // Local delivery
        word(1, 0, 32'h12345678, 6'd9);
        tick();
        word(0, 0, '0, '0);
        tick();
        loc_ready = 1'b1;
        tick();
        loc_ready = 1'b0;

        // Overflow: five pushes into a depth-4 FIFO with no pops
        for (int i = 0; i < 5; i++) begin
            word(1, 0, 32'hA000_0000 + 32'(i), AW'(i + 1));
            tick();
        end
        word(0, 0, '0, '0);
        loc_ready = 1'b1;
        repeat (5) tick();
        loc_ready = 1'b0;

        // Clear overflow through IDLE->RUN, then push into full with a pop
        call_in = 1'b1;
        tick();
        call_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            word(1, 0, 32'hB000_0000 + 32'(i), AW'(i + 10));
            loc_ready = (i == 4);
            tick();
        end
        word(0, 0, '0, '0);
        loc_ready = 1'b1;
        repeat (5) tick();
        loc_ready = 1'b0;

        // Call/ret handshake
        call_in  = 1'b1;
        ret_in   = 1'b0;
        loc_done = 1'b1;
        repeat (2) tick();
        ret_in = 1'b1;
        repeat (2) tick();
        call_in = 1'b0;
        repeat (2) tick();
        ret_in = 1'b0;

        // Ret gated by FIFO contents
        word(1, 0, 32'h0000_0C01, 6'd1);
        tick();
        word(1, 0, 32'h0000_0C02, 6'd2);
        tick();
        word(0, 0, '0, '0);
        call_in = 1'b1;
        ret_in  = 1'b1;
        repeat (3) tick();
        loc_ready = 1'b1;
        repeat (3) tick();
        loc_ready = 1'b0;
        loc_done  = 1'b0;
        call_in   = 1'b0;
        tick();

        // Async reset in the middle of RUN with words in flight
        word(1, 0, 32'h0000_0D01, 6'd3);
        call_in = 1'b1;
        ret_in  = 1'b0;
        tick();
        word(1, 2, 32'h0000_0D02, 6'd4);
        tick();
        word(0, 0, '0, '0);
        call_in = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #2 rst_n = 1'b1;
        tick();

        // All-ones hop count (broadcast only when the build macro is defined)
        word(1, 15, 32'hCAFEF00D, 6'd33);
        tick();
        word(0, 0, '0, '0);
        loc_ready = 1'b1;
        repeat (3) tick();
        loc_ready = 1'b0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) call_in = ~call_in;
            ret_in    = ($urandom_range(0, 1) == 1);
            loc_done  = ($urandom_range(0, 3) != 0);
            loc_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 6) begin
                word(1, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                     $urandom, AW'($urandom));
            end else begin
                word(0, 0, '0, '0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
